// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for a 5-stage RV32I pipeline: stall, flush and memory-wait control.
// Optional build macro PIPE_CTRL_PERF_EN adds saturating stall/flush performance counters.
module pipe_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_write,
    output logic        exmem_write,
    output logic        memwb_write,
    output logic        ifid_hold,
    output logic        idex_hold,
    output logic        exmem_hold,
    output logic        load_stall,
    output logic        mem_err
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     state_reg, state_next;
    logic [7:0] wait_cnt_reg, wait_cnt_next;

    logic mem_stall;
    logic load_use;
    logic eval_run;
    logic freeze;
    logic flush;
    logic lu_stall;
    logic trapped;

    assign mem_stall = mem_req && !mem_ready;
    assign load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                        (id_use_rs2 && (id_rs2 == ex_rd)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= RUN;
            wait_cnt_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Select which action applies this cycle; the output decode below turns it into controls.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = 8'd0;
        eval_run      = 1'b0;
        freeze        = 1'b0;
        flush         = 1'b0;
        lu_stall      = 1'b0;
        trapped       = 1'b0;

        unique case (state_reg)
            RUN: eval_run = 1'b1;
            MEM_WAIT: begin
                if (mem_ready) begin
                    eval_run   = 1'b1;
                    state_next = RUN;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt_reg == TIMEOUT_CNT)
                        state_next = ERR;
                    wait_cnt_next = (wait_cnt_reg == 8'hFF) ? wait_cnt_reg : wait_cnt_reg + 8'd1;
                end
            end
            ERR: trapped = 1'b1;
            default: state_next = RUN;
        endcase

        // The entering cycle is the first stalled cycle, so the counter starts at 1.
        if (eval_run) begin
            if (mem_stall) begin
                freeze        = 1'b1;
                state_next    = MEM_WAIT;
                wait_cnt_next = 8'd1;
            end else if (ex_branch_taken) begin
                flush = 1'b1;
            end else if (load_use) begin
                lu_stall = 1'b1;
            end
        end
    end

    always_comb begin
        pc_write    = !(freeze || lu_stall || trapped);
        ifid_write  = !(flush || trapped);
        idex_write  = !(flush || lu_stall || trapped);
        exmem_write = !trapped;
        memwb_write = !(freeze || trapped);
        ifid_hold   = freeze || lu_stall;
        idex_hold   = freeze;
        exmem_hold  = freeze;
        load_stall  = lu_stall;
        mem_err     = trapped;
        // Bubbles everywhere while reset is held.
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_write = 1'b0;
            ifid_hold   = 1'b0;
            idex_hold   = 1'b0;
            exmem_hold  = 1'b0;
            load_stall  = 1'b0;
            mem_err     = 1'b0;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (!pc_write && !trapped && (stall_cnt != 32'hFFFF_FFFF))
                stall_cnt <= stall_cnt + 32'd1;
            if (flush && (flush_cnt != 32'hFFFF_FFFF))
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: expected control vectors are queued per driven cycle and
// compared against the DUT outputs sampled on the falling edge.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic        pc_write, ifid_write, idex_write, exmem_write, memwb_write;
    logic        ifid_hold, idex_hold, exmem_hold, load_stall, mem_err;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    // {pc, ifid_w, idex_w, exmem_w, memwb_w, ifid_h, idex_h, exmem_h, load_stall, mem_err}
    localparam logic [9:0] V_DEF  = 10'b11111_000_0_0;
    localparam logic [9:0] V_MW   = 10'b01110_111_0_0;
    localparam logic [9:0] V_BR   = 10'b10011_000_0_0;
    localparam logic [9:0] V_LU   = 10'b01011_100_1_0;
    localparam logic [9:0] V_ERR  = 10'b00000_000_0_1;
    localparam logic [9:0] V_ZERO = 10'b00000_000_0_0;

    pipe_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
        .exmem_write(exmem_write), .memwb_write(memwb_write),
        .ifid_hold(ifid_hold), .idex_hold(idex_hold), .exmem_hold(exmem_hold),
        .load_stall(load_stall), .mem_err(mem_err)
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [9:0] outv;
    assign outv = {pc_write, ifid_write, idex_write, exmem_write, memwb_write,
                   ifid_hold, idex_hold, exmem_hold, load_stall, mem_err};

    logic [9:0] exp_q[$];
    int n_cmp = 0;
    int n_mis = 0;
    int m_stall = 0;
    int m_flush = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic [4:0] rd, input logic mr, input logic br,
                         input logic req, input logic rdy);
        id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_rd = rd; ex_mem_read = mr; ex_branch_taken = br;
        mem_req = req; mem_ready = rdy;
    endtask

    task automatic pop_check(input string tag);
        logic [9:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++; n_mis++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, {22'd0, outv}, {22'd0, e});
        end
    endtask

    // One clocked cycle: called at posedge+1, checks at negedge, returns at next posedge+1.
    task automatic step(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd, input logic mr,
                        input logic br, input logic req, input logic rdy, input logic [9:0] exp);
        drive(rs1, rs2, u1, u2, rd, mr, br, req, rdy);
        exp_q.push_back(exp);
        @(negedge clk);
        pop_check(tag);
        @(posedge clk);
        if (!exp[9] && !exp[0]) m_stall++;
        if (exp == V_BR) m_flush++;
        #1;
    endtask

    task automatic check_perf(input string tag);
`ifdef PIPE_CTRL_PERF_EN
        check({tag, "_stall_cnt"}, stall_cnt, 32'(m_stall));
        check({tag, "_flush_cnt"}, flush_cnt, 32'(m_flush));
`else
        $display("info %s: performance counters not built", tag);
`endif
    endtask

    // Asynchronous reset asserted mid-cycle, held over one edge, released on a falling edge.
    task automatic mid_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        exp_q.push_back(V_ZERO);
        pop_check({tag, "_async"});
        m_stall = 0;
        m_flush = 0;
        check_perf({tag, "_async"});
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        exp_q.push_back(V_DEF);
        pop_check({tag, "_release"});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        exp_q.push_back(V_ZERO);
        pop_check("reset_held");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        step("first_cycle", 0, 0, 0, 0, 0, 0, 0, 0, 0, V_DEF);
        step("lu_rs2",      1, 5, 1, 1, 5, 1, 0, 0, 0, V_LU);
        step("lu_release",  1, 5, 1, 1, 7, 0, 0, 0, 0, V_DEF);
        step("lu_rd0",      0, 0, 1, 1, 0, 1, 0, 0, 0, V_DEF);
        step("lu_rs1",      9, 3, 1, 0, 9, 1, 0, 0, 0, V_LU);
        step("lu_unused",   9, 9, 0, 0, 9, 1, 0, 0, 0, V_DEF);
        step("br_over_lu",  1, 5, 1, 1, 5, 1, 1, 0, 0, V_BR);
        check_perf("after_branch");
        step("br_plain",    0, 0, 0, 0, 0, 0, 1, 0, 0, V_BR);

        step("mw_1",        0, 0, 0, 0, 0, 0, 0, 1, 0, V_MW);
        step("mw_2_br_ign", 0, 0, 0, 0, 0, 0, 1, 1, 0, V_MW);
        step("mw_3_lu_ign", 1, 5, 1, 1, 5, 1, 0, 1, 0, V_MW);
        step("mw_ready",    0, 0, 0, 0, 0, 0, 0, 1, 1, V_DEF);
        step("mw_idle",     0, 0, 0, 0, 0, 0, 0, 0, 0, V_DEF);

        step("mwlu_1",      0, 0, 0, 0, 0, 0, 0, 1, 0, V_MW);
        step("mwlu_reqdrop",0, 0, 0, 0, 0, 0, 0, 0, 0, V_MW);
        step("mwlu_ready",  2, 4, 1, 0, 2, 1, 0, 0, 1, V_LU);
        step("mwlu_after",  2, 4, 1, 0, 6, 0, 0, 0, 0, V_DEF);

        step("mwbr_prio",   1, 5, 1, 1, 5, 1, 1, 1, 0, V_MW);
        step("mwbr_ready",  1, 5, 1, 1, 5, 1, 1, 1, 1, V_BR);
        check_perf("after_waits");

        step("rst_pre",     0, 0, 0, 0, 0, 0, 0, 1, 0, V_MW);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        mid_reset("rst_midwait");
        step("rst_first",   0, 0, 0, 0, 0, 0, 0, 0, 0, V_DEF);

        for (int i = 0; i < 3; i++)
            step($sformatf("mw3_%0d", i), 0, 0, 0, 0, 0, 0, 0, 1, 0, V_MW);
        step("mw3_ready",   0, 0, 0, 0, 0, 0, 0, 1, 1, V_DEF);
        check_perf("mw3");
`ifdef PIPE_CTRL_PERF_EN
        check("mw3_stall_is_3", stall_cnt, 32'd3);
`endif

        for (int i = 1; i <= 5; i++)
            step($sformatf("to_wait_%0d", i), 0, 0, 0, 0, 0, 0, 0, 1, 0, V_MW);
        step("to_err_6",    0, 0, 0, 0, 0, 0, 0, 1, 0, V_ERR);
        step("to_err_rdy",  0, 0, 0, 0, 0, 0, 0, 0, 1, V_ERR);
        step("to_err_br",   1, 5, 1, 1, 5, 1, 1, 0, 0, V_ERR);
        check_perf("after_err");

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        mid_reset("rst_err");
        step("post_err",    0, 0, 0, 0, 0, 0, 0, 0, 0, V_DEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
